multistage_retirement_unit: RTL and testbench



---
 rtl/multistage_retirement_unit.sv | 110 +++++++++++
 tb/tb_multistage_retirement_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multistage_retirement_unit.sv
// Retirement FIFO: gathers up to NUM_STAGES retiring instructions per cycle (oldest stage first)
// and presents them one per cycle to destination routing over a valid/ready handshake.
module multistage_retirement_unit #(
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned NUM_FUS        = 4,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned FU_IDX_WIDTH   = $clog2(NUM_FUS),
    parameter int unsigned TIA_WORD_WIDTH = 32,
    parameter int unsigned INSTR_WIDTH    = 32
) (
    input  logic                                         clock,
    input  logic                                         reset_n,
    input  logic [NUM_STAGES-1:0]                        stage_valid,
    input  logic [NUM_STAGES-1:0][INSTR_WIDTH-1:0]       stage_instruction,
    input  logic [NUM_STAGES-1:0][FU_IDX_WIDTH-1:0]      stage_fu,
    input  logic [NUM_FUS-1:0][TIA_WORD_WIDTH-1:0]       fu_result,
    input  logic                                         retire_ready,
    output logic                                         retire_valid,
    output logic [INSTR_WIDTH-1:0]                       retiring_datapath_instruction,
    output logic [TIA_WORD_WIDTH-1:0]                    datapath_result,
    output logic                                         retire_stall,
    output logic [$clog2(DEPTH+1)-1:0]                   occupancy,
    output logic                                         overflow_error
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [INSTR_WIDTH-1:0]    instr_mem  [DEPTH];
    logic [TIA_WORD_WIDTH-1:0] result_mem [DEPTH];
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          next_wr_ptr;

    logic                      pop;
    logic                      drop;
    logic [DEPTH-1:0]          wr_en;
    logic [INSTR_WIDTH-1:0]    wr_instr   [DEPTH];
    logic [TIA_WORD_WIDTH-1:0] wr_result  [DEPTH];
    logic [FU_IDX_WIDTH-1:0]   fu_sel;
    int unsigned               avail;
    int unsigned               count;
    int unsigned               slot;
    int unsigned               s;

    assign retire_valid                  = (occupancy != '0);
    assign retiring_datapath_instruction = retire_valid ? instr_mem[rd_ptr] : '0;
    assign datapath_result               = retire_valid ? result_mem[rd_ptr] : '0;
    assign retire_stall                  = (32'(occupancy) > (DEPTH - NUM_STAGES));

    // Walk stages oldest to youngest; each accepted entry takes the next free slot after wr_ptr,
    // and anything beyond the capacity left after this cycle's pop is dropped.
    always_comb begin
        pop         = retire_valid && retire_ready;
        avail       = DEPTH - 32'(occupancy) + 32'(pop);
        count       = 0;
        slot        = 0;
        s           = 0;
        drop        = 1'b0;
        fu_sel      = '0;
        wr_en       = '0;
        wr_instr    = '{default: '0};
        wr_result   = '{default: '0};
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            s = NUM_STAGES - 1 - i;
            if (stage_valid[STG_W'(s)]) begin
                if (count < avail) begin
                    slot = 32'(wr_ptr) + count;
                    if (slot >= DEPTH) slot = slot - DEPTH;
                    fu_sel                    = stage_fu[STG_W'(s)];
                    wr_en[PTR_W'(slot)]       = 1'b1;
                    wr_instr[PTR_W'(slot)]    = stage_instruction[STG_W'(s)];
                    wr_result[PTR_W'(slot)]   = (32'(fu_sel) < NUM_FUS) ? fu_result[fu_sel]
                                                                        : fu_result[0];
                    count = count + 1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
        slot = 32'(wr_ptr) + count;
        if (slot >= DEPTH) slot = slot - DEPTH;
        next_wr_ptr = PTR_W'(slot);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            occupancy      <= '0;
            overflow_error <= 1'b0;
        end else begin
            if (pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            wr_ptr    <= next_wr_ptr;
            occupancy <= occupancy + OCC_W'(count) - OCC_W'(pop);
            if (drop) overflow_error <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned d = 0; d < DEPTH; d++) begin
            if (wr_en[d]) begin
                instr_mem[d]  <= wr_instr[d];
                result_mem[d] <= wr_result[d];
            end
        end
    end

endmodule

// File: tb/tb_multistage_retirement_unit.sv
// Bench for multistage_retirement_unit: directed scenarios plus random traffic against a queue model;
// a second instance (DEPTH=3, NUM_STAGES=2) exercises pointer wrap.
module tb_multistage_retirement_unit;

    localparam int unsigned NS = 3, NF = 3, D = 4, IW = 16, WW = 16, FW = 2;

    typedef struct {
        logic [IW-1:0] instr;
        logic [WW-1:0] result;
    } entry_t;

    logic                      clock = 1'b0;
    logic                      reset_n = 1'b1;
    logic [NS-1:0]             stage_valid = '0;
    logic [NS-1:0][IW-1:0]     stage_instruction = '0;
    logic [NS-1:0][FW-1:0]     stage_fu = '0;
    logic [NF-1:0][WW-1:0]     fu_result = '0;
    logic                      retire_ready = 1'b0;
    logic                      retire_valid;
    logic [IW-1:0]             ret_instr;
    logic [WW-1:0]             ret_result;
    logic                      retire_stall;
    logic [2:0]                occupancy;
    logic                      overflow_error;

    logic [1:0]                w_valid = '0;
    logic [1:0][IW-1:0]        w_instr = '0;
    logic [1:0][1:0]           w_fu = '0;
    logic [3:0][WW-1:0]        w_res = '0;
    logic                      w_ready = 1'b0;
    logic                      w_retire_valid;
    logic [IW-1:0]             w_ret_instr;
    logic [WW-1:0]             w_result;
    logic                      w_stall;
    logic [1:0]                w_occ;
    logic                      w_ovf;

    entry_t q[$];
    logic   m_ovf = 1'b0;
    int     total = 0;
    int     bad = 0;

    always #5 clock = ~clock;

    multistage_retirement_unit #(
        .NUM_STAGES(NS), .NUM_FUS(NF), .DEPTH(D), .TIA_WORD_WIDTH(WW), .INSTR_WIDTH(IW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .stage_valid(stage_valid), .stage_instruction(stage_instruction),
        .stage_fu(stage_fu), .fu_result(fu_result), .retire_ready(retire_ready),
        .retire_valid(retire_valid), .retiring_datapath_instruction(ret_instr),
        .datapath_result(ret_result), .retire_stall(retire_stall),
        .occupancy(occupancy), .overflow_error(overflow_error)
    );

    multistage_retirement_unit #(
        .NUM_STAGES(2), .NUM_FUS(4), .DEPTH(3), .TIA_WORD_WIDTH(WW), .INSTR_WIDTH(IW)
    ) dut_wrap (
        .clock(clock), .reset_n(reset_n),
        .stage_valid(w_valid), .stage_instruction(w_instr),
        .stage_fu(w_fu), .fu_result(w_res), .retire_ready(w_ready),
        .retire_valid(w_retire_valid), .retiring_datapath_instruction(w_ret_instr),
        .datapath_result(w_result), .retire_stall(w_stall),
        .occupancy(w_occ), .overflow_error(w_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all(input string where);
        entry_t h;
        logic   v;
        v        = (q.size() != 0);
        h.instr  = '0;
        h.result = '0;
        if (v) h = q[0];
        check({where, ":valid"},  64'(retire_valid),   64'(v));
        check({where, ":instr"},  64'(ret_instr),      64'(h.instr));
        check({where, ":result"}, 64'(ret_result),     64'(h.result));
        check({where, ":occ"},    64'(occupancy),      64'(q.size()));
        check({where, ":stall"},  64'(retire_stall),   64'(q.size() > int'(D - NS)));
        check({where, ":ovf"},    64'(overflow_error), 64'(m_ovf));
    endtask

    // Drive one cycle's inputs, advance the model by the queue rules, then check at the next negedge.
    task automatic step(input logic [NS-1:0] v, input logic [NS-1:0][IW-1:0] ins,
                        input logic [NS-1:0][FW-1:0] fu, input logic [NF-1:0][WW-1:0] res,
                        input logic rdy, input string where);
        entry_t e;
        stage_valid       = v;
        stage_instruction = ins;
        stage_fu          = fu;
        fu_result         = res;
        retire_ready      = rdy;
        if (q.size() != 0 && rdy) void'(q.pop_front());
        for (int i = NS - 1; i >= 0; i--) begin
            if (v[i]) begin
                e.instr  = ins[i];
                e.result = (int'(fu[i]) < int'(NF)) ? res[fu[i]] : res[0];
                if (q.size() < int'(D)) q.push_back(e);
                else m_ovf = 1'b1;
            end
        end
        @(negedge clock);
        compare_all(where);
    endtask

    task automatic idle(input logic rdy);
        step('0, '0, '0, '0, rdy, "idle");
    endtask

    task automatic random_step(input bit compliant);
        logic [NS-1:0]         v;
        logic [NS-1:0][IW-1:0] ins;
        logic [NS-1:0][FW-1:0] fu;
        logic [NF-1:0][WW-1:0] res;
        v = NS'($urandom);
        if (compliant && q.size() > int'(D - NS)) v = '0;
        for (int i = 0; i < int'(NS); i++) begin
            ins[i] = IW'($urandom);
            fu[i]  = FW'($urandom);
        end
        for (int f = 0; f < int'(NF); f++) res[f] = WW'($urandom);
        step(v, ins, fu, res, $urandom_range(0, 3) != 0, compliant ? "rand_ok" : "rand_wild");
    endtask

    task automatic mid_reset();
        stage_valid  = '0;
        retire_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid",  64'(retire_valid),   64'(0));
        check("rst_instr",  64'(ret_instr),      64'(0));
        check("rst_result", 64'(ret_result),     64'(0));
        check("rst_occ",    64'(occupancy),      64'(0));
        check("rst_stall",  64'(retire_stall),   64'(0));
        check("rst_ovf",    64'(overflow_error), 64'(0));
        q.delete();
        m_ovf = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        compare_all("post_rst");
    endtask

    initial begin
        logic [NS-1:0][IW-1:0] ins;
        logic [NS-1:0][FW-1:0] fu;
        logic [NF-1:0][WW-1:0] res;

        #1 reset_n = 1'b0;
        #1;
        check("init_valid", 64'(retire_valid),   64'(0));
        check("init_occ",   64'(occupancy),      64'(0));
        check("init_stall", 64'(retire_stall),   64'(0));
        check("init_ovf",   64'(overflow_error), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        compare_all("init");

        // single retire
        ins = '0; fu = '0; res = '0;
        ins[0] = 16'h0C01; res[0] = 16'h0011;
        step(3'b001, ins, fu, res, 1'b1, "single");
        check("single_res", 64'(ret_result), 64'h11);
        idle(1'b1);

        // out-of-range FU select falls back to fu_result[0]
        ins = '0; fu = '0; res = '0;
        fu[0] = 2'd3; res[0] = 16'h0055; res[1] = 16'h0066; res[2] = 16'h0077;
        step(3'b001, ins, fu, res, 1'b1, "fu_oob");
        check("fu_oob_res", 64'(ret_result), 64'h55);
        idle(1'b1);

        // same-cycle ordering: stage 2 before stage 0
        ins = '0; fu = '0; res = '0;
        ins[2] = 16'hA000; fu[2] = 2'd1; res[1] = 16'h00AA;
        ins[0] = 16'hB000; fu[0] = 2'd0; res[0] = 16'h00BB;
        step(3'b101, ins, fu, res, 1'b1, "order");
        check("order_first_res",   64'(ret_result), 64'hAA);
        check("order_first_instr", 64'(ret_instr),  64'hA000);
        idle(1'b1);
        check("order_second_res",   64'(ret_result), 64'hBB);
        check("order_second_instr", 64'(ret_instr),  64'hB000);
        idle(1'b1);

        // backpressure: head held, stall follows registered occupancy
        for (int k = 0; k < 3; k++) begin
            ins = '0; fu = '0; res = '0;
            ins[0] = IW'(16'h0D00 + k); res[0] = WW'(16'h0100 + k);
            step(3'b001, ins, fu, res, 1'b0, "bp_push");
            check("bp_head", 64'(ret_result), 64'h100);
            if (k == 1) check("bp_stall_at_2", 64'(retire_stall), 64'(1));
        end
        for (int k = 0; k < 10 && q.size() != 0; k++) idle(1'b1);
        check("bp_drained", 64'(occupancy), 64'(0));

        // reset with three entries queued, then first post-reset push comes out first
        for (int k = 0; k < 3; k++) begin
            ins = '0; fu = '0; res = '0;
            res[0] = WW'(16'h0200 + k);
            step(3'b001, ins, fu, res, 1'b0, "pre_rst");
        end
        check("pre_rst_occ", 64'(occupancy), 64'(3));
        mid_reset();
        ins = '0; fu = '0; res = '0;
        res[0] = 16'h0077;
        step(3'b001, ins, fu, res, 1'b1, "after_rst");
        check("after_rst_res", 64'(ret_result), 64'h77);

        for (int n = 0; n < 300; n++) random_step(1'b1);
        check("compliant_no_ovf", 64'(overflow_error), 64'(0));
        for (int n = 0; n < 150; n++) random_step(1'b0);
        mid_reset();

        // directed overflow: occupancy 3, no pop, three pushes -> only stage 2 fits
        for (int k = 0; k < 3; k++) begin
            ins = '0; fu = '0; res = '0;
            res[0] = WW'(16'h0300 + k);
            step(3'b001, ins, fu, res, 1'b0, "ovf_fill");
        end
        ins = '0; fu = '0; res = '0;
        ins[2] = 16'hE002; fu[2] = 2'd2; res[2] = 16'h0222;
        ins[1] = 16'hE001; fu[1] = 2'd1; res[1] = 16'h0111;
        ins[0] = 16'hE000; fu[0] = 2'd0; res[0] = 16'h0333;
        step(3'b111, ins, fu, res, 1'b0, "ovf_push");
        check("ovf_occ",  64'(occupancy),      64'(4));
        check("ovf_flag", 64'(overflow_error), 64'(1));
        idle(1'b0);
        check("ovf_held", 64'(overflow_error), 64'(1));
        for (int k = 0; k < 3; k++) idle(1'b1);
        check("ovf_last_entry", 64'(ret_result), 64'h222);
        idle(1'b1);

        // pointer wrap on the DEPTH=3, NUM_STAGES=2 instance
        for (int k = 1; k <= 10; k++) begin
            w_valid = 2'b01; w_res = '0; w_res[0] = WW'(k); w_ready = 1'b1;
            @(negedge clock);
            check("wrap_valid", 64'(w_retire_valid), 64'(1));
            check("wrap_res",   64'(w_result),       64'(k));
            check("wrap_occ",   64'(w_occ),          64'(1));
        end
        w_valid = '0;
        @(negedge clock);
        check("wrap_empty", 64'(w_retire_valid), 64'(0));
        check("wrap_ovf",   64'(w_ovf),          64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
